// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and holds the IF/ID pipeline register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | presenting pc to memory whenever the IF/ID slot can take data
// ST_WAIT  | request accepted, response will be written into IF/ID
// ST_DROP  | request accepted before a redirect, response is discarded
module riscv_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_2000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic [6:0]  if_id_opcode
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_inst_q, if_id_inst_d;

   logic        slot_free;
   logic        req_valid;
   logic        req_fire;
   logic        consume;
   logic [31:0] redirect_tgt;

   // The slot is free when IF/ID is empty or decode takes it this cycle, so
   // a response can never land on an instruction decode has not consumed.
   assign slot_free    = !if_id_valid_q || !id_stall;
   assign consume      = if_id_valid_q && !id_stall;
   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // Request is withdrawn during a redirect and held low while in reset.
   always_comb begin
      req_valid = 1'b0;
      if (rst_n && (state_q == ST_FETCH) && slot_free && !redirect_valid) begin
         req_valid = 1'b1;
      end
   end

   assign req_fire       = req_valid && imem_req_ready;
   assign imem_req_valid = req_valid;
   assign imem_req_addr  = pc_q;

   // Next-state, PC and IF/ID update; a redirect overrides everything else.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;

      if (redirect_valid) begin
         pc_d          = redirect_tgt;
         if_id_valid_d = 1'b0;
         if_id_inst_d  = NOP_INST;
         case (state_q)
            ST_FETCH: state_d = req_fire ? ST_DROP : ST_FETCH;
            ST_WAIT,
            ST_DROP:  state_d = imem_rsp_valid ? ST_FETCH : ST_DROP;
            default:  state_d = ST_FETCH;
         endcase
      end else begin
         if (consume) begin
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
         end
         case (state_q)
            ST_FETCH: begin
               if (req_fire) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  if_id_valid_d = 1'b1;
                  if_id_pc_d    = pc_q;
                  if_id_inst_d  = imem_rsp_data;
                  pc_d          = pc_q + 32'd4;
                  state_d       = ST_FETCH;
               end
            end
            ST_DROP: begin
               if (imem_rsp_valid) begin
                  state_d = ST_FETCH;
               end
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

   // State and pipeline registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= 32'h0000_0000;
         if_id_inst_q  <= NOP_INST;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
      end
   end

   assign if_id_valid  = if_id_valid_q;
   assign if_id_pc     = if_id_pc_q;
   assign if_id_inst   = if_id_inst_q;
   assign if_id_opcode = if_id_inst_q[6:0];

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Testbench for riscv_fetch_stage: randomized memory/decode/redirect traffic
// with a stream-level reference model and a scoreboard on the IF/ID output.
module tb_riscv_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_2000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic [6:0]  if_id_opcode;

   riscv_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_inst     (if_id_inst),
      .if_id_opcode   (if_id_opcode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } item_t;

   item_t       sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          delivered = 0;

   // Stream model: next address the fetcher must request, plus the single
   // outstanding memory transaction (live = its data is still wanted).
   logic [31:0] exp_req_addr = RESET_PC;
   bit          outstanding = 1'b0;
   bit          live = 1'b0;
   int          cnt = 0;
   logic [31:0] o_addr = 32'h0;

   // Stimulus knobs.
   bit          rst_req = 1'b1;
   int          p_ready = 100;
   int          p_stall = 0;
   int          p_redir = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          force_redir = 1'b0;
   logic [31:0] force_tgt = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h0000_2000) return 32'h0050_0093;
      return (addr * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
   endtask

   // One clock cycle of environment: drive inputs, check request side,
   // then advance the reference model at the rising edge.
   task automatic cycle();
      logic        redir;
      logic        rsp_now;
      logic        acc;
      logic        exp_v;
      logic [31:0] tgt;
      @(negedge clk);
      rst_n = !rst_req;
      if (rst_req) begin
         outstanding  = 1'b0;
         live         = 1'b0;
         exp_req_addr = RESET_PC;
         sb.delete();
         redir   = 1'b0;
         rsp_now = ($urandom_range(1, 0) == 1);
      end else begin
         redir   = force_redir || ($urandom_range(99, 0) < p_redir);
         rsp_now = outstanding && (cnt == 1);
      end
      tgt = force_redir ? force_tgt : $urandom();
      force_redir    = 1'b0;
      redirect_valid = redir;
      redirect_pc    = redir ? tgt : $urandom();
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(o_addr) : $urandom();
      id_stall       = ($urandom_range(99, 0) < p_stall);
      imem_req_ready = ($urandom_range(99, 0) < p_ready);
      #1;
      exp_v = !rst_req && !outstanding && !((sb.size() != 0) && id_stall) && !redir;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_v});
      if (exp_v && imem_req_valid) chk("req_addr", imem_req_addr, exp_req_addr);
      acc = imem_req_valid && imem_req_ready;
      @(posedge clk);
      if (!rst_req) begin
         if (rsp_now) outstanding = 1'b0;
         else if (outstanding) cnt--;
         if (redir) begin
            sb.delete();
            exp_req_addr = tgt & 32'hFFFF_FFFC;
            live = 1'b0;
         end else if (rsp_now && live) begin
            sb.push_back('{pc: o_addr, inst: mem_word(o_addr)});
            exp_req_addr = o_addr + 32'd4;
         end
         if (acc) begin
            outstanding = 1'b1;
            live        = 1'b1;
            cnt         = $urandom_range(lat_max, lat_min);
            o_addr      = exp_req_addr;
         end
      end
   endtask

   // mode 0: waiting on a response more than one cycle away; mode 1: the
   // response arrives in the next cycle.
   task automatic wait_for(input int mode);
      int n = 0;
      while (!(outstanding && live && ((mode == 0) ? (cnt >= 2) : (cnt == 1)))) begin
         if (n == 100) begin
            n_checks++;
            $display("FAIL wait_for_%0d: got timeout after %0d cycles required condition reached", mode, n);
            return;
         end
         cycle();
         n++;
      end
   endtask

   // Monitor: compares the IF/ID register against the scoreboard every cycle
   // and pops an entry whenever decode consumes it.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, sb.size() != 0});
         if (if_id_valid && (sb.size() != 0)) begin
            chk("if_id_pc", if_id_pc, sb[0].pc);
            chk("if_id_inst", if_id_inst, sb[0].inst);
            chk("if_id_opcode", {25'b0, if_id_opcode}, {25'b0, sb[0].inst[6:0]});
            if (!id_stall) begin
               void'(sb.pop_front());
               delivered++;
            end
         end else if (!if_id_valid) begin
            chk("nop_inst", if_id_inst, NOP_INST);
            chk("nop_opcode", {25'b0, if_id_opcode}, 32'h13);
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      repeat (2) cycle();
      rst_req = 1'b0;
      repeat (12) cycle();

      p_ready = 20;
      repeat (40) cycle();

      p_ready = 100; p_stall = 70;
      repeat (40) cycle();

      p_stall = 0; lat_min = 3; lat_max = 3;
      wait_for(0);
      force_redir = 1'b1; force_tgt = 32'h0000_3002;
      cycle();
      repeat (10) cycle();

      lat_min = 2; lat_max = 2;
      wait_for(1);
      force_redir = 1'b1; force_tgt = 32'h4000_0010;
      cycle();
      repeat (10) cycle();

      lat_min = 1; lat_max = 1;
      force_redir = 1'b1; force_tgt = 32'hFFFF_FFFE;
      cycle();
      repeat (10) cycle();

      lat_min = 3; lat_max = 3;
      wait_for(0);
      rst_req = 1'b1;
      repeat (2) cycle();
      rst_req = 1'b0;
      repeat (10) cycle();

      repeat (20) begin
         p_ready = $urandom_range(100, 20);
         p_stall = $urandom_range(60, 0);
         p_redir = $urandom_range(15, 0);
         lat_min = 1;
         lat_max = $urandom_range(4, 1);
         repeat (100) cycle();
      end

      chk("progress", {31'b0, delivered >= 50}, 32'h1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
Instruction-fetch stage of the RISC-V core. It owns the PC, issues word fetches to instruction memory over a valid/ready request plus a response-valid channel, and holds the IF/ID pipeline register. Its opcode output feeds the decode-stage control generator directly. It accepts stall from the hazard unit and redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_2000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction presented while the IF/ID register is invalid (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_req_addr  output  32  word-aligned fetch address.
imem_rsp_valid  input  1  fetch data valid; at most one per accepted request, never in the acceptance cycle.
imem_rsp_data  input  32  fetched instruction.
id_stall  input  1  decode cannot consume IF/ID this cycle.
redirect_valid  input  1  branch taken or jump; discard the younger stream.
redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_pc  output  32  PC of the IF/ID instruction.
if_id_inst  output  32  IF/ID instruction, or NOP_INST when invalid.
if_id_opcode  output  7  if_id_inst[6:0], to the control decoder.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, imem_req_valid=0 while reset is asserted. A reset mid-transaction abandons any outstanding request. The first request issues in the first cycle after reset deassertion.
- At most one outstanding request. States:
  - FETCH: imem_req_valid = slot_free, where slot_free = !if_id_valid || !id_stall; imem_req_addr=pc. On valid&&ready, go to WAIT. Addr/valid stay stable until accepted, unless a redirect occurs.
  - WAIT: imem_req_valid=0. On imem_rsp_valid: if_id_inst<=rsp_data, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4 (wraps mod 2^32), go to FETCH.
  - DROP: imem_req_valid=0. On imem_rsp_valid, discard the data and go to FETCH.
- Decode consumption: when if_id_valid && !id_stall && no new response, if_id_valid<=0 and if_id_inst<=NOP_INST. When a response arrives, slot_free is guaranteed, so the register is overwritten and no data is lost.
- Stall: while id_stall && if_id_valid, the IF/ID register holds its value and no new request issues. An already-outstanding response may still land only if the slot is free at issue time, which is guaranteed by the slot_free gating.
- Redirect (highest priority, any state):
  - pc<={redirect_pc[31:2],2'b00}, if_id_valid<=0, if_id_inst<=NOP_INST.
  - If currently in WAIT without rsp_valid this cycle, or in FETCH with a request accepted this cycle, go to DROP.
  - If rsp_valid arrives in the same cycle, discard it and go to FETCH.
  - If in DROP: if rsp_valid arrives this cycle, go to FETCH; otherwise stay in DROP.
  - Redirect overrides id_stall. An un-accepted request is withdrawn; the next cycle presents the new address.
- if_id_opcode is purely combinational from if_id_inst. No other combinational paths exist from inputs to outputs except imem_req_valid depending on id_stall and redirect_valid (valid is forced to 0 during a redirect cycle).
- Throughput with single-cycle memory: one instruction per 2 cycles (request, then response).

Test Plan:
- Reset release, imem ready=1, 1-cycle response returning 0x00500093 -> first req addr 0x2000; if_id_valid=1, pc=0x2000, opcode=0x13; next req addr 0x2004.
- Memory holds ready=0 for 3 cycles -> imem_req_valid stays 1 with addr stable at 0x2004; IF/ID drains to NOP and valid=0 after decode consumes it.
- id_stall=1 for 4 cycles with if_id_valid=1 -> if_id_* unchanged, no request issued; on release, the next request issues the following cycle.
- Redirect to 0x3002 while in WAIT -> next response discarded, IF/ID valid=0, next request addr 0x3000.
- Redirect coincident with rsp_valid -> data dropped, no DROP state, next request addr = redirect target the following cycle.
- rst_n asserted during WAIT, response arrives during reset -> ignored; after release, request addr=0x2000 and if_id_valid=0.
